// File: rtl/equalizer_pkg.sv
// Shared widths, complex sample types and the product sign-extension helper
// for the equalizer conjugate-multiply stage.
package equalizer_pkg;

    localparam int IN_W       = 16;
    localparam int PROD_W     = 22;
    localparam int OUT_W      = PROD_W + 1;
    localparam int TAG_W      = 6;
    localparam int NUM_SC     = 48;
    localparam int CNT_W      = $clog2(NUM_SC + 1);
    localparam int SIDE_DEPTH = 4;

    typedef struct packed {
        logic signed [IN_W-1:0] re;
        logic signed [IN_W-1:0] im;
    } cplx_in_t;

    typedef struct packed {
        logic signed [OUT_W-1:0] re;
        logic signed [OUT_W-1:0] im;
    } cplx_out_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             last;
    } side_t;

    function automatic logic signed [OUT_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(OUT_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/equalizer_cmul_side_dly.sv
// Enabled delay line carrying {valid, tag, last} alongside the arithmetic
// pipeline so the sideband lines up with the sum register.
module equalizer_cmul_side_dly
    import equalizer_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  en_i,
    input  side_t side_i,
    output side_t side_o
);

    side_t [SIDE_DEPTH-1:0] stage_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q <= {stage_q[SIDE_DEPTH-2:0], side_i};
        end
    end

    assign side_o = stage_q[SIDE_DEPTH-1];

endmodule

// File: rtl/equalizer_mul16s.sv
// 16s x 16s multiplier keeping the low PROD_W bits, three clock-enabled
// register stages: operand, raw product, output product.
module equalizer_mul16s
    import equalizer_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ce_i,
    input  logic signed [IN_W-1:0]   a_i,
    input  logic signed [IN_W-1:0]   b_i,
    output logic signed [PROD_W-1:0] p_o
);

    logic signed [IN_W-1:0]   a_q;
    logic signed [IN_W-1:0]   b_q;
    logic signed [PROD_W-1:0] tmp_q;
    logic signed [PROD_W-1:0] p_q;

    // Low bits of a two's-complement product do not depend on extension width,
    // so truncating inside the cast gives the wrapped PROD_W result directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            tmp_q <= '0;
            p_q   <= '0;
        end else if (ce_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            tmp_q <= PROD_W'(a_q * b_q);
            p_q   <= tmp_q;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/equalizer_cmul_conj.sv
// Streaming y = x * conj(h) with valid/ready flow control, tag pass-through
// and a sticky per-symbol subcarrier count check.
module equalizer_cmul_conj
    import equalizer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [IN_W-1:0]  x_re,
    input  logic signed [IN_W-1:0]  x_im,
    input  logic signed [IN_W-1:0]  h_re,
    input  logic signed [IN_W-1:0]  h_im,
    input  logic [TAG_W-1:0]        s_tag,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] y_re,
    output logic signed [OUT_W-1:0] y_im,
    output logic [TAG_W-1:0]        m_tag,
    output logic                    m_last,
    output logic                    len_err,
    input  logic                    len_err_clr
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SC - 1);

    // Handshake: a beat moves on a cycle where valid & ready. The whole pipeline
    // shares one enable, so a stalled output freezes every stage including
    // bubbles, and s_ready is that enable with no path from s_valid.
    logic en;
    assign en      = ~m_valid | m_ready;
    assign s_ready = en;

    cplx_in_t x_c;
    cplx_in_t h_c;
    assign x_c = '{re: x_re, im: x_im};
    assign h_c = '{re: h_re, im: h_im};

    logic signed [PROD_W-1:0] p0;
    logic signed [PROD_W-1:0] p1;
    logic signed [PROD_W-1:0] p2;
    logic signed [PROD_W-1:0] p3;

    equalizer_mul16s u_mul_p0 (.clk(clk), .reset_n(reset_n), .ce_i(en), .a_i(x_c.re), .b_i(h_c.re), .p_o(p0));
    equalizer_mul16s u_mul_p1 (.clk(clk), .reset_n(reset_n), .ce_i(en), .a_i(x_c.im), .b_i(h_c.im), .p_o(p1));
    equalizer_mul16s u_mul_p2 (.clk(clk), .reset_n(reset_n), .ce_i(en), .a_i(x_c.im), .b_i(h_c.re), .p_o(p2));
    equalizer_mul16s u_mul_p3 (.clk(clk), .reset_n(reset_n), .ce_i(en), .a_i(x_c.re), .b_i(h_c.im), .p_o(p3));

    side_t side_in;
    side_t side_out;
    assign side_in = '{valid: s_valid, tag: s_tag, last: s_last};

    equalizer_cmul_side_dly u_side_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (en),
        .side_i  (side_in),
        .side_o  (side_out)
    );

    cplx_out_t y_d;
    cplx_out_t y_q;

    always_comb begin
        y_d.re = sext_prod(p0) + sext_prod(p1);
        y_d.im = sext_prod(p2) - sext_prod(p3);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q <= '0;
        end else if (en) begin
            y_q <= y_d;
        end
    end

    assign m_valid = side_out.valid;
    assign m_tag   = side_out.tag;
    assign m_last  = side_out.last;
    assign y_re    = y_q.re;
    assign y_im    = y_q.im;

    logic             hs;
    logic             len_set;
    logic [CNT_W-1:0] sc_cnt_d;
    logic [CNT_W-1:0] sc_cnt_q;
    logic             len_err_d;
    logic             len_err_q;

    assign hs = m_valid & m_ready;

    // A set condition in the same cycle as a clear request leaves the flag set.
    always_comb begin
        sc_cnt_d  = sc_cnt_q;
        len_err_d = len_err_q;
        len_set   = 1'b0;
        if (hs) begin
            if (m_last) begin
                len_set  = (sc_cnt_q != LAST_IDX);
                sc_cnt_d = '0;
            end else if (sc_cnt_q == LAST_IDX) begin
                len_set  = 1'b1;
                sc_cnt_d = '0;
            end else begin
                sc_cnt_d = sc_cnt_q + 1'b1;
            end
        end
        if (len_err_clr) begin
            len_err_d = 1'b0;
        end
        if (len_set) begin
            len_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sc_cnt_q  <= '0;
            len_err_q <= 1'b0;
        end else begin
            sc_cnt_q  <= sc_cnt_d;
            len_err_q <= len_err_d;
        end
    end

    assign len_err = len_err_q;

endmodule

// File: tb/tb_equalizer_cmul_conj.sv
// Directed bench for equalizer_cmul_conj: vector table, streaming symbols,
// backpressure, length-error and asynchronous mid-stream reset sequences.
module tb_equalizer_cmul_conj;
    import equalizer_pkg::*;

    localparam int EXP_W = TAG_W + 1 + 2 * OUT_W;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    s_valid = 1'b0;
    logic                    s_ready;
    logic signed [IN_W-1:0]  x_re = '0;
    logic signed [IN_W-1:0]  x_im = '0;
    logic signed [IN_W-1:0]  h_re = '0;
    logic signed [IN_W-1:0]  h_im = '0;
    logic [TAG_W-1:0]        s_tag = '0;
    logic                    s_last = 1'b0;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [OUT_W-1:0] y_re;
    logic signed [OUT_W-1:0] y_im;
    logic [TAG_W-1:0]        m_tag;
    logic                    m_last;
    logic                    len_err;
    logic                    len_err_clr = 1'b0;

    equalizer_cmul_conj dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .x_re        (x_re),
        .x_im        (x_im),
        .h_re        (h_re),
        .h_im        (h_im),
        .s_tag       (s_tag),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .y_re        (y_re),
        .y_im        (y_im),
        .m_tag       (m_tag),
        .m_last      (m_last),
        .len_err     (len_err),
        .len_err_clr (len_err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [IN_W-1:0]  xr;
        logic signed [IN_W-1:0]  xi;
        logic signed [IN_W-1:0]  hr;
        logic signed [IN_W-1:0]  hi;
        logic [TAG_W-1:0]        tag;
        logic                    last;
        logic signed [OUT_W-1:0] er;
        logic signed [OUT_W-1:0] ei;
    } vec_t;

    vec_t             vecs[8];
    logic [EXP_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_pass = 0;
    int               rdy_mode = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input int xr, input int xi, input int hr, input int hi,
                                input int tag, input bit last, input int er, input int ei);
        vec_t v;
        v.xr = IN_W'(xr);
        v.xi = IN_W'(xi);
        v.hr = IN_W'(hr);
        v.hi = IN_W'(hi);
        v.tag = TAG_W'(tag);
        v.last = last;
        v.er = OUT_W'(er);
        v.ei = OUT_W'(ei);
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v);
        int guard = 0;
        s_valid = 1'b1;
        x_re = v.xr;
        x_im = v.xi;
        h_re = v.hr;
        h_im = v.hi;
        s_tag = v.tag;
        s_last = v.last;
        @(negedge clk);
        while (!s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            exp_q.push_back({v.tag, v.last, v.er, v.ei});
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin : ready_drv
        int cyc;
        cyc = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       m_ready = (cyc % 3 == 0);
                2:       m_ready = 1'b0;
                default: m_ready = 1'b1;
            endcase
            cyc++;
        end
    end

    initial begin : monitor
        logic [EXP_W-1:0]        e;
        logic                    stall_prev;
        logic signed [OUT_W-1:0] pr;
        logic signed [OUT_W-1:0] pi;
        logic [TAG_W-1:0]        pt;
        stall_prev = 1'b0;
        pr = '0;
        pi = '0;
        pt = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_hold_valid", m_valid, 1);
                    check("stall_hold_re", y_re, pr);
                    check("stall_hold_im", y_im, pi);
                    check("stall_hold_tag", m_tag, pt);
                end
                if (rdy_mode == 1) check("s_ready_vs_stall", s_ready, !(m_valid && !m_ready));
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got tag %0d, expected no beat", m_tag);
                    end else begin
                        e = exp_q.pop_front();
                        check("y_re", y_re, $signed(e[2*OUT_W-1:OUT_W]));
                        check("y_im", y_im, $signed(e[OUT_W-1:0]));
                        check("m_tag", m_tag, e[EXP_W-1 -: TAG_W]);
                        check("m_last", m_last, e[2*OUT_W]);
                    end
                end
                stall_prev = m_valid && !m_ready;
                pr = y_re;
                pi = y_im;
                pt = m_tag;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cnt;
        vecs[0] = mk(3, 4, 1, 2, 5, 1'b0, 11, -2);
        vecs[1] = mk(-1023, -1023, 1023, -1023, 1, 1'b0, 0, -2093058);
        vecs[2] = mk(1023, 1023, 1023, 1023, 2, 1'b0, 2093058, 0);
        vecs[3] = mk(0, 0, 5, 5, 3, 1'b0, 0, 0);
        vecs[4] = mk(-7, 2, 3, -4, 4, 1'b0, -29, -22);
        vecs[5] = mk(100, -200, -50, 25, 6, 1'b0, -10000, 7500);
        vecs[6] = mk(1, 0, 0, 1, 7, 1'b0, 0, -1);
        vecs[7] = mk(0, 1, 0, 1, 8, 1'b0, 1, 0);

        do_reset();
        check("rst_m_valid", m_valid, 0);
        check("rst_y_re", y_re, 0);
        check("rst_y_im", y_im, 0);
        check("rst_m_tag", m_tag, 0);
        check("rst_m_last", m_last, 0);
        check("rst_len_err", len_err, 0);
        check("rst_s_ready", s_ready, 1);

        // Single beat with exact four-cycle latency and a one-cycle valid pulse.
        s_valid = 1'b1;
        x_re = 3; x_im = 4; h_re = 1; h_im = 2; s_tag = 5; s_last = 1'b0;
        exp_q.push_back({TAG_W'(5), 1'b0, OUT_W'(11), OUT_W'(-2)});
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            check((n == 4) ? "lat_valid_hi" : "lat_valid_lo", m_valid, (n == 4));
        end
        drain("single");

        foreach (vecs[i]) send(vecs[i]);
        drain("table");

        do_reset();
        for (int k = 0; k < NUM_SC; k++) send(mk(k, 0, 1, 1, k, (k == NUM_SC - 1), k, -k));
        drain("b2b");
        check("b2b_len_err", len_err, 0);

        rdy_mode = 1;
        for (int k = 1; k <= 10; k++) send(mk(k, 2 * k, 1, 1, k + 10, 1'b0, 3 * k, k));
        drain("bp");
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        do_reset();
        for (int k = 0; k < 40; k++) send(mk(k, 1, 1, 0, k, (k == 39), k, 1));
        drain("short_sym");
        check("short_len_err_set", len_err, 1);
        len_err_clr = 1'b1;
        @(posedge clk);
        #1;
        len_err_clr = 1'b0;
        check("len_err_cleared", len_err, 0);
        for (int k = 0; k < NUM_SC; k++) send(mk(k, 0, 2, 0, k, (k == NUM_SC - 1), 2 * k, 0));
        drain("good_sym");
        check("good_len_err", len_err, 0);
        for (int k = 0; k < NUM_SC; k++) send(mk(0, k, 1, 0, k, 1'b0, 0, k));
        drain("nolast_sym");
        check("wrap_len_err_set", len_err, 1);
        repeat (3) @(posedge clk);
        #1;
        check("len_err_sticky", len_err, 1);

        // Fill a stalled pipeline: one beat at the output, three in flight.
        do_reset();
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) send(mk(10 + k, 0, 1, 0, 20 + k, 1'b0, 10 + k, 0));
        check("pre_rst_m_valid", m_valid, 1);
        check("pre_rst_y_re", y_re, 10);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_m_valid", m_valid, 0);
        check("async_rst_y_re", y_re, 0);
        check("async_rst_y_im", y_im, 0);
        check("async_rst_m_tag", m_tag, 0);
        exp_q.delete();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1);
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (m_valid) cnt++;
        end
        check("no_stale_beats", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
